// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-port signals shared by the arbiter and its neighbours.
// The slave modport is the arbiter's view; the master modport is the view of the requesters and memory.
`default_nettype none

interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_write;
  logic [31:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, m_addr, m_wdata, m_write
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, m_addr, m_wdata, m_write
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Shares one memory port between fetch and load/store with wait states.    |
// | Option: MEM_ARB_ROUND_ROBIN_EN (round-robin on contention, else data     |
// |         requester has fixed priority).                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic        last_grant;
  logic        owner;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        any_req;
  logic        grant_data;
  logic        final_cycle;

  assign any_req     = bus.i_req | bus.d_req;
  assign final_cycle = (state == ACCESS) && (wait_cnt == 4'd0);

  // On contention, round-robin favours the side not served last; otherwise data always wins.
  always_comb begin
    grant_data = bus.d_req;
    if (bus.i_req && bus.d_req) begin
      grant_data = ROUND_ROBIN ? ~last_grant : 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      i_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= grant_data;
            last_grant <= grant_data;
            lat_addr   <= grant_data ? bus.d_addr : bus.i_addr;
            lat_wdata  <= grant_data ? bus.d_wdata : 32'd0;
            lat_we     <= grant_data & bus.d_we;
            wait_cnt   <= WAIT_INIT;
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (!lat_we) begin
            if (owner) begin
              d_rdata_q <= bus.m_rdata;
            end else begin
              i_rdata_q <= bus.m_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    bus.m_addr  = 32'd0;
    bus.m_wdata = 32'd0;
    bus.m_write = 1'b0;
    bus.i_ack   = 1'b0;
    bus.d_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        bus.m_addr  = lat_addr;
        bus.m_wdata = lat_wdata;
        bus.m_write = final_cycle & lat_we;
        if (final_cycle) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.i_ack  = ~owner;
        bus.d_ack  = owner;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (WAIT_CYCLES 1 and 0), each with a small memory model.
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  mem_port_arbiter_if ifa ();
  mem_port_arbiter_if ifb ();

  mem_port_arbiter #(.WAIT_CYCLES(1)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  mem_port_arbiter #(.WAIT_CYCLES(0)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic        pre_we_a, pre_we_b;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  assign ifa.m_rdata = mem_a[ifa.m_addr[9:2]];
  assign ifb.m_rdata = mem_b[ifb.m_addr[9:2]];

  always @(posedge clk) begin
    if (pre_we_a) mem_a[pre_idx] <= pre_val;
    else if (ifa.m_write) mem_a[ifa.m_addr[9:2]] <= ifa.m_wdata;
  end

  always @(posedge clk) begin
    if (pre_we_b) mem_b[pre_idx] <= pre_val;
    else if (ifb.m_write) mem_b[ifb.m_addr[9:2]] <= ifb.m_wdata;
  end

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int passed = 0;
  int total  = 0;
  int ack_a  = 0;
  int dack_a = 0;
  int wr_a   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (ifa.i_ack || ifa.d_ack) begin
      ack_a++;
      if (ifa.d_ack) dack_a++;
      if (q_a.size() == 0) begin
        chk("a_unexpected_ack", 64'({ifa.i_ack, ifa.d_ack}), 64'd0);
      end else begin
        e = q_a.pop_front();
        chk("a_ack", 64'({ifa.i_ack, ifa.d_ack, (ifa.d_ack ? ifa.d_rdata : ifa.i_rdata)}),
            64'({~e.is_data, e.is_data, e.rdata}));
      end
    end
    if (ifa.m_write) wr_a++;
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (ifb.i_ack || ifb.d_ack) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_ack", 64'({ifb.i_ack, ifb.d_ack}), 64'd0);
      end else begin
        e = q_b.pop_front();
        chk("b_ack", 64'({ifb.i_ack, ifb.d_ack, (ifb.d_ack ? ifb.d_rdata : ifb.i_rdata)}),
            64'({~e.is_data, e.is_data, e.rdata}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit to_b, input logic [7:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    if (to_b) pre_we_b = 1'b1;
    else pre_we_a = 1'b1;
    tick();
    pre_we_a = 1'b0;
    pre_we_b = 1'b0;
  endtask

  // Returns just after the edge that ends the DONE cycle of the target-th acknowledge.
  task automatic wait_acks_a(input int target, input string name);
    int n;
    n = 0;
    while (ack_a < target && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (ack_a < target) chk(name, 64'(ack_a), 64'(target));
  endtask

  function automatic exp_t mk(input logic is_data, input logic [31:0] rdata);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = rdata;
    return e;
  endfunction

  initial begin
    int ack_cyc, t, base, c1, c2;
    logic [31:0] exp_d;

    rst_a = 1'b1; rst_b = 1'b1;
    pre_we_a = 1'b0; pre_we_b = 1'b0; pre_idx = 8'd0; pre_val = 32'd0;
    ifa.i_req = 1'b0; ifa.i_addr = 32'd0; ifa.d_req = 1'b0; ifa.d_we = 1'b0;
    ifa.d_addr = 32'd0; ifa.d_wdata = 32'd0;
    ifb.i_req = 1'b0; ifb.i_addr = 32'd0; ifb.d_req = 1'b0; ifb.d_we = 1'b0;
    ifb.d_addr = 32'd0; ifb.d_wdata = 32'd0;

    preload(1'b0, 8'h04, 32'h12345678);
    preload(1'b0, 8'h08, 32'h00000000);
    preload(1'b0, 8'h10, 32'h11111111);
    preload(1'b1, 8'h00, 32'hA0A0A0A0);
    preload(1'b1, 8'h01, 32'hB1B1B1B1);
    tick();
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", 64'({ifa.i_ack, ifa.d_ack, ifa.m_write, ifa.m_addr}), 64'd0);
    chk("reset_wdata", 64'(ifa.m_wdata), 64'd0);
    chk("reset_rdata", {ifa.i_rdata, ifa.d_rdata}, 64'd0);
    tick();
    exp_d = 32'd0;

    // Fetch with WAIT_CYCLES=1: address on the port in cycles 1-2, ack in cycle 3.
    ifa.i_addr = 32'h10; ifa.i_req = 1'b1;
    q_a.push_back(mk(1'b0, 32'h12345678));
    ack_cyc = -1;
    for (int c = 0; c < 40 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2) chk($sformatf("fetch_maddr_c%0d", c), 64'(ifa.m_addr), 64'h10);
      if (ifa.i_ack) ack_cyc = c;
    end
    chk("fetch_latency", 64'(ack_cyc), 64'd3);
    tick();
    ifa.i_req = 1'b0;

    // Store, then load back; the store must not disturb d_rdata.
    base = wr_a;
    t = ack_a + 1;
    ifa.d_addr = 32'h20; ifa.d_wdata = 32'hCAFEF00D; ifa.d_we = 1'b1; ifa.d_req = 1'b1;
    q_a.push_back(mk(1'b1, exp_d));
    wait_acks_a(t, "store_timeout");
    ifa.d_req = 1'b0; ifa.d_we = 1'b0;
    chk("store_mwrite_cycles", 64'(wr_a - base), 64'd1);

    t = ack_a + 1;
    ifa.d_req = 1'b1;
    exp_d = 32'hCAFEF00D;
    q_a.push_back(mk(1'b1, exp_d));
    wait_acks_a(t, "load_timeout");
    ifa.d_req = 1'b0;

    // Both requesters held high across three grants.
    t = ack_a + 3;
    ifa.i_addr = 32'h10; ifa.d_addr = 32'h20; ifa.d_we = 1'b0;
    ifa.i_req = 1'b1; ifa.d_req = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    q_a.push_back(mk(1'b0, 32'h12345678));
    q_a.push_back(mk(1'b1, exp_d));
    q_a.push_back(mk(1'b0, 32'h12345678));
`else
    q_a.push_back(mk(1'b1, exp_d));
    q_a.push_back(mk(1'b1, exp_d));
    q_a.push_back(mk(1'b1, exp_d));
`endif
    wait_acks_a(t, "contend_timeout");
    ifa.i_req = 1'b0; ifa.d_req = 1'b0;
    tick();

    // Data request arrives while a fetch is in ACCESS.
    t = ack_a + 1;
    base = dack_a;
    ifa.i_addr = 32'h10; ifa.i_req = 1'b1;
    q_a.push_back(mk(1'b0, 32'h12345678));
    tick();
    ifa.d_addr = 32'h20; ifa.d_we = 1'b0; ifa.d_req = 1'b1;
    q_a.push_back(mk(1'b1, exp_d));
    wait_acks_a(t, "late_fetch_timeout");
    ifa.i_req = 1'b0;
    wait_acks_a(t + 1, "late_data_timeout");
    ifa.d_req = 1'b0;
    repeat (6) tick();
    chk("late_data_ack_once", 64'(dack_a - base), 64'd1);

    // Reset in the first ACCESS cycle of a store to 0x40.
    t = ack_a;
    ifa.d_addr = 32'h40; ifa.d_wdata = 32'hDEADBEEF; ifa.d_we = 1'b1; ifa.d_req = 1'b1;
    tick();
    chk("rst_pre_maddr", 64'(ifa.m_addr), 64'h40);
    rst_a = 1'b1;
    #1;
    chk("rst_async_ctrl", 64'({ifa.i_ack, ifa.d_ack, ifa.m_write, ifa.m_addr}), 64'd0);
    chk("rst_async_wdata", 64'(ifa.m_wdata), 64'd0);
    ifa.d_req = 1'b0; ifa.d_we = 1'b0;
    tick();
    tick();
    rst_a = 1'b0;
    repeat (4) tick();
    chk("rst_no_ack", 64'(ack_a), 64'(t));
    chk("rst_mem_intact", 64'(mem_a[16]), 64'h11111111);
    chk("rst_rdata_cleared", {ifa.i_rdata, ifa.d_rdata}, 64'd0);

    // WAIT_CYCLES=0: ack in cycle 2, back-to-back fetches 3 cycles apart.
    c1 = -1; c2 = -1;
    ifb.i_addr = 32'h0; ifb.i_req = 1'b1;
    q_b.push_back(mk(1'b0, 32'hA0A0A0A0));
    q_b.push_back(mk(1'b0, 32'hB1B1B1B1));
    for (int c = 0; c < 30 && c2 < 0; c++) begin
      @(negedge clk);
      if (ifb.i_ack) begin
        if (c1 < 0) begin
          c1 = c;
          ifb.i_addr = 32'h4;
        end else begin
          c2 = c;
          ifb.i_req = 1'b0;
        end
      end
    end
    ifb.i_req = 1'b0;
    chk("b_first_latency", 64'(c1), 64'd2);
    chk("b_spacing", 64'(c2 - c1), 64'd3);

    repeat (4) tick();
    chk("a_queue_drained", 64'(q_a.size()), 64'd0);
    chk("b_queue_drained", 64'(q_b.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing arbiter that shares the single memory port (combinational read, write on rising `clk`) between the instruction-fetch requester and the load/store requester. It accepts level requests from both sides, grants one, drives the memory port for a programmable number of wait cycles, captures read data and returns a one-cycle acknowledge. It sits between the processor datapath and the `memory` instance, replacing the separate instruction ROM in the multi-cycle/pipelined variants.

## Interface
- `WAIT_CYCLES`, 1, extra access cycles before the memory operation completes; legal 0..15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  instruction-fetch request (level, held until `i_ack`).
- `i_addr`  in  32  fetch byte address.
- `i_ack`  out  1  one-cycle pulse: fetch complete, `i_rdata` valid.
- `i_rdata`  out  32  fetched word; holds until next `i_ack`.
- `d_req`  in  1  data request (level, held until `d_ack`).
- `d_we`  in  1  1 = store, 0 = load; sampled with `d_req` at grant.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_ack`  out  1  one-cycle pulse: data access complete.
- `d_rdata`  out  32  load data; holds until next `d_ack`; unchanged by stores.
- `m_addr`  out  32  memory address.
- `m_wdata`  out  32  memory write data.
- `m_write`  out  1  memory write enable.
- `m_rdata`  in  32  memory read data (combinational from `m_addr`).

## Operation
- States: IDLE, ACCESS, DONE. 4-bit down-counter `wait_cnt`; 1-bit `last_grant` (0 = fetch, 1 = data).
- IDLE: no request -> stay. Any request -> pick winner (see Configuration), latch addr, wdata, we (we forced 0 for fetch), owner; `wait_cnt <= WAIT_CYCLES`; -> ACCESS; `last_grant <= owner`.
- ACCESS: `m_addr`/`m_wdata` driven from latched values. `wait_cnt != 0` -> decrement, stay. `wait_cnt == 0` (final cycle): `m_write = latched we`; owner's rdata register `<= m_rdata` on loads/fetches only; -> DONE.
- DONE: owner's ack = 1 for exactly this cycle; -> IDLE unconditionally.
- Requester deasserts req at the edge ending DONE; a req still high in the following IDLE is a new request.
- Requests arriving while not IDLE are not acknowledged until a later IDLE grant; the non-granted requester keeps req high and is served next.
- Addresses and data pass through unmodified; no alignment checks.
- Outside ACCESS: `m_addr = 0`, `m_wdata = 0`, `m_write = 0`.

## Timing
- Reset values: state IDLE, `wait_cnt = 0`, `last_grant = 1`, all outputs 0 including `i_rdata`, `d_rdata`.
- Latency from req seen in IDLE (cycle 0) to ack: cycle `WAIT_CYCLES + 2`. `WAIT_CYCLES = 0` -> ack in cycle 2; `= 1` -> cycle 3.
- Back-to-back throughput: one access per `WAIT_CYCLES + 3` cycles.
- `m_write` high for exactly one cycle per store, final ACCESS cycle only; memory commits at that cycle's closing edge.
- Reset asserted mid-ACCESS: outputs drop immediately (async); if before the final ACCESS edge, no write commits, no ack, rdata not updated.
- `WAIT_CYCLES` > 15 is illegal; counter width fixed at 4.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on simultaneous `i_req` and `d_req` in IDLE, grant the port opposite to `last_grant`. After reset, first contended grant goes to fetch.
- Undefined: fixed priority, data wins every contended grant; fetch served only when `d_req` low in IDLE. `last_grant` still updated but unused.

## Test plan
- Reset, `WAIT_CYCLES=1`: all outputs 0; `i_req=1, i_addr=0x10`, mem word 0x12345678 -> `m_addr=0x10` for cycles 1-2, `i_ack` in cycle 3 only, `i_rdata=0x12345678`.
- Store `d_addr=0x20, d_wdata=0xCAFEF00D, d_we=1` -> `m_write` high exactly one cycle; subsequent load of 0x20 returns 0xCAFEF00D; `d_rdata` unchanged by the store.
- Simultaneous requests held high for three grants: with macro -> order fetch, data, fetch; without -> data, data, data (fetch starved).
- `WAIT_CYCLES=0`: ack in cycle 2; back-to-back fetches 0x0, 0x4 ack 3 cycles apart.
- Reset asserted in first ACCESS cycle of a store to 0x40 (old value 0x11111111) -> no ack, word at 0x40 still 0x11111111, outputs 0 immediately.
- Data request arriving during a fetch's ACCESS -> fetch completes, data granted in next IDLE, `d_ack` exactly once.
